// File: rtl/cordic_sram_resp_if.sv
// Bus bundle between the CORDIC engine / host datapath (master) and the
// sample-buffer responder (slave): engine SRAM port plus load/drain streams.
interface cordic_sram_resp_if #(
    parameter int DW = 16,
    parameter int AW = 5
);
    logic          ce_n;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          eng_start;
    logic          eng_finish;
    logic          host_start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          done;
    logic          err;

    modport master (
        output ce_n, we, addr, wdata, eng_finish, host_start,
               in_valid, in_data, out_ready,
        input  rdata, eng_start, in_ready, out_valid, out_data, done, err
    );

    modport slave (
        input  ce_n, we, addr, wdata, eng_finish, host_start,
               in_valid, in_data, out_ready,
        output rdata, eng_start, in_ready, out_valid, out_data, done, err
    );
endinterface

// File: rtl/cordic_sram_resp.sv
// Sample-buffer responder for the CORDIC engine SRAM bus: batch load, engine run, drain.
// Define CORDIC_SRAM_ERR_EN to build the sticky protocol-error detector on err.
module cordic_sram_resp #(
    parameter int DW    = 16,
    parameter int AW    = 5,
    parameter int DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    cordic_sram_resp_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [DW-1:0] mem [DEPTH];

    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          eng_start_q, eng_start_d;
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] out_data_q, out_data_d;
    logic          issued_q, issued_d;
    logic          done_q, done_d;
    logic          in_ready_c;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rdata_d     = rdata_q;
        eng_start_d = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        issued_d    = issued_q;
        done_d      = 1'b0;
        in_ready_c  = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = bus.in_data;
        case (state_q)
            IDLE: begin
                if (bus.host_start) begin
                    state_d = LOAD;
                    ptr_d   = '0;
                end
            end
            LOAD: begin
                in_ready_c = 1'b1;
                if (bus.in_valid) begin
                    mem_we = 1'b1;
                    if (ptr_q == LAST) begin
                        state_d     = RUN;
                        ptr_d       = '0;
                        eng_start_d = 1'b1;
                    end else begin
                        ptr_d = ptr_q + AW'(1);
                    end
                end
            end
            RUN: begin
                if (!bus.ce_n) begin
                    if (bus.we) begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.addr;
                        mem_wdata = bus.wdata;
                    end else begin
                        rdata_d = mem[bus.addr];
                    end
                end
                if (bus.eng_finish) begin
                    state_d  = DRAIN;
                    ptr_d    = '0;
                    issued_d = 1'b0;
                end
            end
            DRAIN: begin
                // issued_q marks that the final word already sits in the output stage
                if (out_valid_q && bus.out_ready && issued_q) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    done_d      = 1'b1;
                end else if ((!out_valid_q || bus.out_ready) && !issued_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = mem[ptr_q];
                    if (ptr_q == LAST) issued_d = 1'b1;
                    else               ptr_d    = ptr_q + AW'(1);
                end else if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            rdata_q     <= '0;
            eng_start_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            issued_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rdata_q     <= rdata_d;
            eng_start_q <= eng_start_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            issued_q    <= issued_d;
            done_q      <= done_d;
        end
    end

    // Buffer contents survive reset; a new batch rewrites every word.
    always_ff @(posedge clk) begin
        if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
    end

`ifdef CORDIC_SRAM_ERR_EN
    logic err_q;
    logic err_evt;

    assign err_evt = (!bus.ce_n && state_q != RUN) ||
                     (bus.in_valid && state_q != LOAD) ||
                     (bus.eng_finish && state_q != RUN);

    always_ff @(posedge clk) begin
        if (rst) err_q <= 1'b0;
        else     err_q <= err_q | err_evt;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.rdata     = rdata_q;
    assign bus.eng_start = eng_start_q;
    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.done      = done_q;
endmodule

// File: tb/tb_cordic_sram_resp.sv
// Self-checking bench for cordic_sram_resp: buffer model, randomized data and handshakes.
module tb_cordic_sram_resp;
    localparam int DW = 16;
    localparam int AW = 5;
    localparam int DEPTH = 32;

`ifdef CORDIC_SRAM_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [DW-1:0] stim    [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];

    cordic_sram_resp_if #(.DW(DW), .AW(AW)) bus ();

    cordic_sram_resp #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        bus.ce_n = 1'b1; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        bus.eng_finish = 1'b0; bus.host_start = 1'b0;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    endtask

    task automatic fill_stim(input int mode, input int base);
        for (int i = 0; i < DEPTH; i++)
            stim[i] = (mode == 0) ? DW'(base + i) : DW'($urandom);
    endtask

    // Start a batch and stream stim[] in, with in_valid high one cycle out of (gap+1).
    task automatic load_batch(input int gap);
        int i = 0;
        int cyc = 0;
        bit take;
        bus.host_start = 1'b1;
        tick;
        bus.host_start = 1'b0;
        while (i < DEPTH && cyc < 4000) begin
            bus.in_valid = ((cyc % (gap + 1)) == 0);
            bus.in_data  = bus.in_valid ? stim[i] : DW'($urandom);
            take = bus.in_valid && bus.in_ready;
            tick;
            cyc++;
            if (take) begin
                ref_mem[i] = stim[i];
                i++;
            end
            if (i < DEPTH) begin
                n_cmp++;
                if (bus.in_ready !== 1'b1 || bus.eng_start !== 1'b0) begin
                    n_bad++;
                    $display("FAIL load_stay beat=%0d in_ready=%b eng_start=%b want 1/0", i, bus.in_ready, bus.eng_start);
                end
            end
        end
        bus.in_valid = 1'b0;
        n_cmp++;
        if (i != DEPTH) begin
            n_bad++;
            $display("FAIL load_timeout beats=%0d want %0d", i, DEPTH);
        end
        n_cmp++;
        if (bus.eng_start !== 1'b1 || bus.in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL run_entry eng_start=%b in_ready=%b want 1/0", bus.eng_start, bus.in_ready);
        end
    endtask

    task automatic finish_engine(input int wait_cyc);
        for (int k = 0; k < wait_cyc; k++) begin
            tick;
            n_cmp++;
            if (bus.eng_start !== 1'b0) begin
                n_bad++;
                $display("FAIL eng_start_once cycle=%0d got %b want 0", k, bus.eng_start);
            end
        end
        bus.eng_finish = 1'b1;
        tick;
        bus.eng_finish = 1'b0;
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL drain_first out_valid=%b want 0", bus.out_valid);
        end
    endtask

    // mode 0: ready always, 1: pattern 1,0,0, 2: random. Stops after nwords handshakes.
    task automatic drain(input int mode, input int nwords);
        int got = 0;
        int cyc = 0;
        bit take;
        bit hold = 1'b0;
        logic [DW-1:0] held;
        while (got < nwords && cyc < 4000) begin
            case (mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = ((cyc % 3) == 0);
                default: bus.out_ready = 1'($urandom);
            endcase
            if (hold) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin
                    n_bad++;
                    $display("FAIL drain_stable valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, held);
                end
            end
            take = bus.out_valid && bus.out_ready;
            if (take) begin
                n_cmp++;
                if (bus.out_data !== ref_mem[got]) begin
                    n_bad++;
                    $display("FAIL drain_data idx=%0d got %h want %h", got, bus.out_data, ref_mem[got]);
                end
            end
            hold = bus.out_valid && !bus.out_ready;
            held = bus.out_data;
            tick;
            cyc++;
            if (take) got++;
            if (got < DEPTH) begin
                n_cmp++;
                if (bus.done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL done_early word=%0d done=%b", got, bus.done);
                end
            end
        end
        bus.out_ready = 1'b0;
        n_cmp++;
        if (got != nwords) begin
            n_bad++;
            $display("FAIL drain_timeout words=%0d want %0d", got, nwords);
        end
        if (nwords == DEPTH) begin
            n_cmp++;
            if (bus.done !== 1'b1 || bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL done_pulse done=%b out_valid=%b want 1/0", bus.done, bus.out_valid);
            end
            if (mode == 0) begin
                n_cmp++;
                if (cyc != DEPTH + 1) begin
                    n_bad++;
                    $display("FAIL drain_rate cycles=%0d want %0d", cyc, DEPTH + 1);
                end
            end
            tick;
            n_cmp++;
            if (bus.done !== 1'b0 || bus.out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL done_once done=%b out_valid=%b want 0/0", bus.done, bus.out_valid);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        n_cmp++;
        if (bus.rdata !== '0 || bus.eng_start !== 1'b0 || bus.in_ready !== 1'b0 ||
            bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
            n_bad++;
            $display("FAIL %s rdata=%h es=%b ir=%b ov=%b od=%h dn=%b er=%b want all 0", tag,
                     bus.rdata, bus.eng_start, bus.in_ready, bus.out_valid, bus.out_data, bus.done, bus.err);
        end
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        tick; tick;
        check_reset_outputs("reset_state");
        rst = 1'b0;
        tick;
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_load;
        fill_stim(0, 0);
        load_batch(0);
        finish_engine(5);
        drain(0, DEPTH);
    endtask

    task automatic test_engine_rw;
        logic [DW-1:0] prev;
        fill_stim(1, 0);
        load_batch(0);
        bus.ce_n = 1'b0; bus.we = 1'b1; bus.addr = 5'd3; bus.wdata = 16'hBEEF;
        tick;
        ref_mem[3] = 16'hBEEF;
        bus.we = 1'b0;
        tick;
        n_cmp++;
        if (bus.rdata !== 16'hBEEF) begin
            n_bad++;
            $display("FAIL raw_read got %h want beef", bus.rdata);
        end
        bus.ce_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.addr = AW'($urandom);
            tick;
            n_cmp++;
            if (bus.rdata !== 16'hBEEF) begin
                n_bad++;
                $display("FAIL rdata_hold got %h want beef", bus.rdata);
            end
        end
        for (int k = 0; k < 40; k++) begin
            int a;
            a = $urandom_range(DEPTH - 1);
            bus.ce_n = 1'b0; bus.addr = AW'(a); bus.we = 1'($urandom); bus.wdata = DW'($urandom);
            prev = bus.rdata;
            tick;
            n_cmp++;
            if (bus.we) begin
                ref_mem[a] = bus.wdata;
                if (bus.rdata !== prev) begin
                    n_bad++;
                    $display("FAIL rdata_on_write got %h want %h", bus.rdata, prev);
                end
            end else if (bus.rdata !== ref_mem[a]) begin
                n_bad++;
                $display("FAIL rand_read addr=%0d got %h want %h", a, bus.rdata, ref_mem[a]);
            end
        end
        bus.ce_n = 1'b1; bus.we = 1'b0;
        finish_engine(1);
        drain(2, DEPTH);
    endtask

    task automatic test_backpressure;
        fill_stim(1, 0);
        load_batch(0);
        finish_engine(2);
        drain(1, DEPTH);
    endtask

    task automatic test_bubbled_load;
        fill_stim(1, 0);
        load_batch(2);
        finish_engine(3);
        drain(0, DEPTH);
    endtask

    task automatic test_reset_mid_drain;
        fill_stim(1, 0);
        load_batch(0);
        finish_engine(2);
        drain(0, 10);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_reset_outputs("reset_mid_drain");
        fill_stim(0, 100);
        load_batch(0);
        finish_engine(4);
        drain(2, DEPTH);
    endtask

    task automatic test_err;
        logic [DW-1:0] prev;
        fill_stim(1, 0);
        load_batch(0);
        finish_engine(2);
        // Stray engine traffic during DRAIN must not touch the buffer or rdata.
        prev = bus.rdata;
        for (int k = 0; k < 6; k++) begin
            bus.ce_n = 1'b0; bus.we = (k % 2 == 0); bus.addr = AW'($urandom);
            bus.wdata = DW'($urandom); bus.in_valid = (k == 3); bus.eng_finish = (k == 4);
            tick;
            n_cmp++;
            if (bus.rdata !== prev) begin
                n_bad++;
                $display("FAIL rdata_outside_run got %h want %h", bus.rdata, prev);
            end
        end
        idle_inputs();
        n_cmp++;
        if (bus.err !== ERR_ON) begin
            n_bad++;
            $display("FAIL err_drain got %b want %b", bus.err, ERR_ON);
        end
        drain(2, DEPTH);
        bus.ce_n = 1'b0; bus.we = 1'b1; bus.addr = '0; bus.wdata = 16'h1234;
        tick;
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick;
            n_cmp++;
            if (bus.err !== ERR_ON) begin
                n_bad++;
                $display("FAIL err_sticky got %b want %b", bus.err, ERR_ON);
            end
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check_reset_outputs("err_cleared");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load();
        test_engine_rw();
        test_backpressure();
        test_bubbled_load();
        test_reset_mid_drain();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
